// File: rtl/bk_add_sched_if.sv
// Request/result bundle for bk_add_sched: two requesters share one adder,
// results come back on a single valid/ready channel tagged with the requester id.
interface bk_add_sched_if #(
  parameter int WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready
  );
endinterface

// File: rtl/bk_add_sched.sv
// Two-requester WIDTH-bit adder built around one SLICE-bit Brent-Kung adder,
// walked over the operand slices one per clock, with round-robin arbitration.
module bk_add_sched #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bk_add_sched_if.slave  bus
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int TOPD  = 1 << ($clog2(SLICE) - 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Brent-Kung prefix adder: up-sweep builds power-of-two group generates,
  // down-sweep fills the remaining positions; carry-in folds into bit 0.
  function automatic logic [SLICE:0] bk_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] gg;
    logic [SLICE-1:0] pp;
    logic [SLICE-1:0] s;
    p     = x ^ y;
    g     = x & y;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < SLICE; d = d * 2) begin
      for (int i = 2 * d - 1; i < SLICE; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = TOPD; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < SLICE; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    s[0] = p[0] ^ ci;
    for (int i = 1; i < SLICE; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    return {gg[SLICE-1], s};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic [SLICE:0]   slice_res;

  always_comb begin
    gnt_vld     = bus.req0_valid | bus.req1_valid;
    gnt_id      = bus.req1_valid & (~bus.req0_valid | ptr_q);
    slice_res   = bk_slice(a_q[SLICE-1:0], b_q[SLICE-1:0], carry_q);

    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d     = gnt_id ? bus.req1_a   : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b   : bus.req0_b;
          carry_d = gnt_id ? bus.req1_cin : bus.req0_cin;
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Operands shift down and the sum fills from the top, so slice k
        // always sits in the low bits while being added and ends at its own position.
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        sum_d   = {slice_res[SLICE-1:0], sum_q[WIDTH-1:SLICE]};
        carry_d = slice_res[SLICE];
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Control and visible result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Operand shift registers carry no reset; they are reloaded on every accept
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held
  assign bus.req0_ready = rst_n & (state_q == IDLE) & gnt_vld & ~gnt_id;
  assign bus.req1_ready = rst_n & (state_q == IDLE) & gnt_vld &  gnt_id;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = sum_q;
  assign bus.res_cout   = carry_q;
  assign bus.res_id     = id_q;

endmodule
